// File: rtl/calc_fmt_pkg.sv
// Shared state encoding and ASCII constants for the result formatter.
package calc_fmt_pkg;

  localparam logic [2:0] StateIdle  = 3'd0;
  localparam logic [2:0] StateSign  = 3'd1;
  localparam logic [2:0] StateDigit = 3'd2;
  localparam logic [2:0] StateCr    = 3'd3;
  localparam logic [2:0] StateLf    = 3'd4;
  localparam logic [2:0] StateDone  = 3'd5;

  typedef enum logic [2:0] {
    StIdle  = StateIdle,
    StSign  = StateSign,
    StDigit = StateDigit,
    StCr    = StateCr,
    StLf    = StateLf,
    StDone  = StateDone
  } fmt_state_e;

  localparam logic [7:0] ASCII_MINUS   = 8'h2D;
  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] ASCII_LF      = 8'h0A;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_HEX_OFS = 8'h37;

endpackage

// File: rtl/nibble_to_ascii.sv
// Maps a 4-bit value to its uppercase ASCII hex character.
module nibble_to_ascii
  import calc_fmt_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);

  always_comb begin
    if (i_nibble < 4'd10) begin
      o_ascii = ASCII_ZERO + {4'b0000, i_nibble};
    end else begin
      o_ascii = ASCII_HEX_OFS + {4'b0000, i_nibble};
    end
  end

endmodule

// File: rtl/result_formatter.sv
// Renders a captured 32-bit result as ASCII hex (optional sign and CR LF) over valid/ready.
module result_formatter
  import calc_fmt_pkg::*;
#(
  parameter bit SIGNED         = 1'b1,
  parameter bit SUPPRESS_ZEROS = 1'b0,
  parameter bit APPEND_CRLF    = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_calc_done,
  input  logic [31:0] i_calc_res,
  input  logic        i_tx_ready,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  output logic        o_busy,
  output logic        o_fmt_done,
  output logic        o_overrun
);

  fmt_state_e  r_state;
  fmt_state_e  w_state_next;
  logic [31:0] r_mag;
  logic [2:0]  r_idx;
  logic        r_seen;
  logic        r_overrun;

  logic        w_neg;
  logic [31:0] w_mag_in;
  logic [3:0]  w_nibble;
  logic [7:0]  w_digit;
  logic        w_skip;

  assign w_neg    = SIGNED && i_calc_res[31];
  assign w_mag_in = w_neg ? (~i_calc_res + 32'd1) : i_calc_res;
  assign w_nibble = r_mag[{r_idx, 2'b00} +: 4];
  // Leading zeros are dropped, but the units digit is always sent.
  assign w_skip   = SUPPRESS_ZEROS && !r_seen && (w_nibble == 4'd0) && (r_idx != 3'd0);

  nibble_to_ascii u_nibble_to_ascii (
    .i_nibble (w_nibble),
    .o_ascii  (w_digit)
  );

  always_comb begin
    w_state_next = r_state;
    o_tx_valid   = 1'b0;
    o_tx_data    = 8'h00;
    o_busy       = 1'b1;
    o_fmt_done   = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_busy = 1'b0;
        if (i_calc_done) begin
          w_state_next = w_neg ? StSign : StDigit;
        end
      end
      StSign: begin
        o_tx_valid = 1'b1;
        o_tx_data  = ASCII_MINUS;
        if (i_tx_ready) begin
          w_state_next = StDigit;
        end
      end
      StDigit: begin
        if (!w_skip) begin
          o_tx_valid = 1'b1;
          o_tx_data  = w_digit;
          if (i_tx_ready && (r_idx == 3'd0)) begin
            w_state_next = APPEND_CRLF ? StCr : StDone;
          end
        end
      end
      StCr: begin
        o_tx_valid = 1'b1;
        o_tx_data  = ASCII_CR;
        if (i_tx_ready) begin
          w_state_next = StLf;
        end
      end
      StLf: begin
        o_tx_valid = 1'b1;
        o_tx_data  = ASCII_LF;
        if (i_tx_ready) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        o_busy       = 1'b0;
        o_fmt_done   = 1'b1;
        w_state_next = StIdle;
      end
      default: begin
        o_busy       = 1'b0;
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_mag     <= 32'd0;
      r_idx     <= 3'd0;
      r_seen    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_overrun <= i_calc_done && (r_state != StIdle);
      case (r_state)
        StIdle: begin
          if (i_calc_done) begin
            r_mag  <= w_mag_in;
            r_idx  <= 3'd7;
            r_seen <= 1'b0;
          end
        end
        StDigit: begin
          if (w_skip) begin
            r_idx <= r_idx - 3'd1;
          end else if (i_tx_ready) begin
            r_seen <= 1'b1;
            if (r_idx != 3'd0) begin
              r_idx <= r_idx - 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_result_formatter.sv
// Randomized bench for result_formatter across three parameter sets, checked against a text model.
module tb_result_formatter;

  localparam int NCFG = 3;
  // cfg0: defaults; cfg1: signed + zero suppression; cfg2: unsigned, suppression, no CR LF.
  localparam bit [NCFG-1:0] CFG_SIGNED = 3'b011;
  localparam bit [NCFG-1:0] CFG_SUPP   = 3'b110;
  localparam bit [NCFG-1:0] CFG_CRLF   = 3'b011;

  logic            clk = 1'b0;
  logic            rst;
  logic            calc_done;
  logic [31:0]     calc_res;
  logic [NCFG-1:0] tx_ready;
  logic [NCFG-1:0] tx_valid;
  logic [NCFG-1:0] busy;
  logic [NCFG-1:0] fmt_done;
  logic [NCFG-1:0] overrun;
  logic [7:0]      tx_data [NCFG];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    result_formatter #(
      .SIGNED         (CFG_SIGNED[g]),
      .SUPPRESS_ZEROS (CFG_SUPP[g]),
      .APPEND_CRLF    (CFG_CRLF[g])
    ) u_dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_calc_done (calc_done),
      .i_calc_res  (calc_res),
      .i_tx_ready  (tx_ready[g]),
      .o_tx_valid  (tx_valid[g]),
      .o_tx_data   (tx_data[g]),
      .o_busy      (busy[g]),
      .o_fmt_done  (fmt_done[g]),
      .o_overrun   (overrun[g])
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] got_b [NCFG][16];
  int         got_n [NCFG];
  int         skip_cnt [NCFG];
  int         fmt_cnt [NCFG];
  int         fmt_t [NCFG];
  int         last_xfer_t [NCFG];
  int         first_valid_t [NCFG];
  int         ovr_cnt [NCFG];
  int         ovr_t [NCFG];
  int         busy_bad [NCFG];
  int         fmt_busy_bad [NCFG];
  int         stall_rem [NCFG];
  logic       prev_stall [NCFG];
  logic [7:0] prev_data [NCFG];

  logic [7:0] exp_b [NCFG][16];
  int         exp_n [NCFG];
  int         exp_skip [NCFG];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected byte stream derived from the hex text of the magnitude.
  task automatic build_exp(input logic [31:0] v);
    for (int g = 0; g < NCFG; g++) begin
      bit         neg;
      logic [31:0] mag;
      string      s;
      int         st;
      int         n;
      logic [7:0] c;
      neg = CFG_SIGNED[g] && v[31];
      mag = neg ? (32'd0 - v) : v;
      s   = $sformatf("%h", mag);
      st  = 0;
      if (CFG_SUPP[g]) begin
        while (st < 7 && s[st] == "0") st++;
      end
      exp_skip[g] = st;
      n = 0;
      if (neg) begin
        exp_b[g][n] = 8'h2D;
        n++;
      end
      for (int i = st; i < 8; i++) begin
        c = s[i];
        if (c >= 8'h61 && c <= 8'h66) c = c - 8'h20;
        exp_b[g][n] = c;
        n++;
      end
      if (CFG_CRLF[g]) begin
        exp_b[g][n]   = 8'h0D;
        exp_b[g][n+1] = 8'h0A;
        n += 2;
      end
      exp_n[g] = n;
    end
  endtask

  task automatic clear_track();
    for (int g = 0; g < NCFG; g++) begin
      got_n[g]         = 0;
      skip_cnt[g]      = 0;
      fmt_cnt[g]       = 0;
      fmt_t[g]         = -1;
      last_xfer_t[g]   = -1;
      first_valid_t[g] = -1;
      ovr_cnt[g]       = 0;
      ovr_t[g]         = -1;
      busy_bad[g]      = 0;
      fmt_busy_bad[g]  = 0;
      stall_rem[g]     = 5;
      prev_stall[g]    = 1'b0;
      prev_data[g]     = 8'h00;
    end
  endtask

  task automatic sample(input int t);
    for (int g = 0; g < NCFG; g++) begin
      if (prev_stall[g]) begin
        check($sformatf("hold_valid[%0d]", g), 32'(tx_valid[g]), 32'd1);
        check($sformatf("hold_data[%0d]", g), 32'(tx_data[g]), 32'(prev_data[g]));
      end
      if (tx_valid[g] && first_valid_t[g] < 0) first_valid_t[g] = t;
      if (busy[g] && !tx_valid[g]) skip_cnt[g]++;
      if (tx_valid[g] && tx_ready[g]) begin
        if (got_n[g] < 16) got_b[g][got_n[g]] = tx_data[g];
        got_n[g]++;
        last_xfer_t[g] = t;
      end
      prev_stall[g] = tx_valid[g] && !tx_ready[g];
      prev_data[g]  = tx_data[g];
      if (fmt_done[g]) begin
        fmt_cnt[g]++;
        fmt_t[g] = t;
        if (busy[g]) fmt_busy_bad[g]++;
      end
      if (overrun[g]) begin
        ovr_cnt[g]++;
        ovr_t[g] = t;
      end
      if (t >= 1 && fmt_cnt[g] == 0 && !busy[g]) busy_bad[g]++;
    end
  endtask

  // mode 0: always ready; 1: random ready; 2: ready low 5 cycles while the 3rd byte is offered.
  task automatic run_txn(input logic [31:0] v, input int mode, input int ovr_at,
                         input logic [31:0] ovr_v);
    int t;
    bit done;
    build_exp(v);
    clear_track();
    t    = 0;
    done = 1'b0;
    while (t < 400 && !done) begin
      @(posedge clk); #1;
      calc_done = (t == 0) || (t == ovr_at);
      calc_res  = (t == 0) ? v : ((t == ovr_at) ? ovr_v : $urandom());
      for (int g = 0; g < NCFG; g++) begin
        case (mode)
          1: tx_ready[g] = ($urandom_range(0, 3) != 0);
          2: begin
            if (got_n[g] == 2 && stall_rem[g] > 0) begin
              tx_ready[g] = 1'b0;
              stall_rem[g]--;
            end else begin
              tx_ready[g] = 1'b1;
            end
          end
          default: tx_ready[g] = 1'b1;
        endcase
      end
      @(negedge clk);
      sample(t);
      done = 1'b1;
      for (int g = 0; g < NCFG; g++) if (fmt_cnt[g] == 0) done = 1'b0;
      t++;
    end
    check($sformatf("finished %h", v), 32'(done), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      calc_done = 1'b0;
      tx_ready  = '1;
      @(negedge clk);
      sample(t);
      t++;
    end
    for (int g = 0; g < NCFG; g++) begin
      check($sformatf("len[%0d] %h", g, v), 32'(got_n[g]), 32'(exp_n[g]));
      for (int i = 0; i < exp_n[g] && i < 16; i++) begin
        check($sformatf("byte%0d[%0d] %h", i, g, v), 32'(got_b[g][i]), 32'(exp_b[g][i]));
      end
      check($sformatf("skips[%0d] %h", g, v), 32'(skip_cnt[g]), 32'(exp_skip[g]));
      check($sformatf("fmt_cnt[%0d]", g), 32'(fmt_cnt[g]), 32'd1);
      check($sformatf("fmt_time[%0d]", g), 32'(fmt_t[g]), 32'(last_xfer_t[g] + 1));
      check($sformatf("fmt_busy[%0d]", g), 32'(fmt_busy_bad[g]), 32'd0);
      check($sformatf("busy_gap[%0d]", g), 32'(busy_bad[g]), 32'd0);
      check($sformatf("ovr_cnt[%0d]", g), 32'(ovr_cnt[g]), (ovr_at > 0) ? 32'd1 : 32'd0);
      if (ovr_at > 0) begin
        check($sformatf("ovr_time[%0d]", g), 32'(ovr_t[g]), 32'(ovr_at + 1));
      end
    end
    if (mode == 0) begin
      check("first_latency", 32'(first_valid_t[0]), 32'd1);
    end
  endtask

  // Reset asserted once cfg0 has transferred 'after' bytes; stream must stop dead.
  task automatic run_rst(input logic [31:0] v, input int after);
    int  t;
    bit  fired;
    build_exp(v);
    clear_track();
    t     = 0;
    fired = 1'b0;
    while (t < 100 && !fired) begin
      @(posedge clk); #1;
      calc_done = (t == 0);
      calc_res  = v;
      tx_ready  = '1;
      if (t > 0 && got_n[0] == after) begin
        rst   = 1'b1;
        fired = 1'b1;
      end
      @(negedge clk);
      if (!fired) sample(t);
      t++;
    end
    check("rst_fired", 32'(fired), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      rst       = 1'b0;
      calc_done = 1'b0;
      @(negedge clk);
      for (int g = 0; g < NCFG; g++) begin
        check($sformatf("rst_valid[%0d]", g), 32'(tx_valid[g]), 32'd0);
        check($sformatf("rst_busy[%0d]", g), 32'(busy[g]), 32'd0);
        check($sformatf("rst_fmt[%0d]", g), 32'(fmt_done[g]), 32'd0);
      end
    end
    check("rst_xfers", 32'(got_n[0]), 32'(after));
    for (int i = 0; i < after; i++) begin
      check($sformatf("rst_byte%0d", i), 32'(got_b[0][i]), 32'(exp_b[0][i]));
    end
  endtask

  initial begin
    logic [31:0] v;
    int          sel;
    int          mode;
    int          ovr_at;
    rst       = 1'b1;
    calc_done = 1'b0;
    calc_res  = 32'd0;
    tx_ready  = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NCFG; g++) begin
      check($sformatf("reset_valid[%0d]", g), 32'(tx_valid[g]), 32'd0);
      check($sformatf("reset_data[%0d]", g), 32'(tx_data[g]), 32'd0);
      check($sformatf("reset_busy[%0d]", g), 32'(busy[g]), 32'd0);
      check($sformatf("reset_fmt[%0d]", g), 32'(fmt_done[g]), 32'd0);
      check($sformatf("reset_ovr[%0d]", g), 32'(overrun[g]), 32'd0);
    end
    // calc_done together with reset must not capture.
    @(posedge clk); #1;
    calc_done = 1'b1;
    calc_res  = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    rst       = 1'b0;
    calc_done = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NCFG; g++) begin
      check($sformatf("rst_done_valid[%0d]", g), 32'(tx_valid[g]), 32'd0);
      check($sformatf("rst_done_busy[%0d]", g), 32'(busy[g]), 32'd0);
    end

    run_txn(32'h0000_000A, 0, -1, 32'd0);
    run_txn(32'hFFFF_FFFE, 0, -1, 32'd0);
    run_txn(32'h0000_0000, 0, -1, 32'd0);
    run_txn(32'h8000_0000, 0, -1, 32'd0);
    run_txn(32'h1234_5678, 2, -1, 32'd0);
    run_txn(32'h0000_ABCD, 0, 3, 32'h0000_1234);
    run_rst(32'hDEAD_BEEF, 4);
    run_txn(32'h0000_0001, 0, -1, 32'd0);

    for (int it = 0; it < 25; it++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       v = $urandom();
        1:       v = 32'($urandom_range(0, 255));
        2:       v = 32'd0 - 32'($urandom_range(1, 4095));
        default: v = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 31'($urandom_range(0, 15))};
      endcase
      mode   = $urandom_range(0, 2);
      ovr_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : -1;
      run_txn(v, mode, ovr_at, $urandom());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/result_formatter.md
Name: result_formatter

Overview:
Back end of the UART calculator datapath. Captures the 32-bit result and single-cycle done pulse from the arithmetic units (add/sub/mul), then renders the result as ASCII hex text. Optional leading '-' for negative values, optional CR LF terminator. Streams one byte at a time to the UART transmitter over a valid/ready handshake. Mirror image of the parser, which converts ASCII input to operands.

Parameters:
SIGNED, 1, 1 = treat calc_res as two's complement; emit '-' plus magnitude when bit 31 set. 0 = raw unsigned.
SUPPRESS_ZEROS, 0, 1 = skip leading zero digits; at least one digit always emitted.
APPEND_CRLF, 1, 1 = emit 0x0D then 0x0A after the last digit.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
calc_done  in  1  single-cycle pulse; calc_res valid in the same cycle
calc_res  in  32  result from the arithmetic unit
tx_ready  in  1  UART TX can accept a byte this cycle
tx_valid  out  1  tx_data holds a byte to send
tx_data  out  8  ASCII byte
busy  out  1  high from capture until the last byte is accepted
fmt_done  out  1  one-cycle pulse after the last byte transfer
overrun  out  1  one-cycle pulse when calc_done arrives while busy

Behaviour:
- Reset (rst high at a clk edge): state IDLE. tx_valid=0, tx_data=0x00, busy=0, fmt_done=0, overrun=0. Internal result register and digit counter cleared. Reset mid-stream aborts the stream immediately; no further bytes are sent and no fmt_done is issued.
- Transfer occurs on a cycle where tx_valid && tx_ready. While tx_valid=1 and tx_ready=0, tx_data must stay stable. tx_valid never drops without a transfer.
- FSM states: IDLE, SIGN, DIGIT, CR, LF, DONE.
- IDLE:
  - On calc_done, latch calc_res; busy=1 from the next cycle.
  - neg = SIGNED && calc_res[31].
  - mag = neg ? (~calc_res + 1) : calc_res, 32-bit. 0x80000000 gives magnitude 0x80000000.
  - Digit index is set to 7.
  - Next state is SIGN if neg, else DIGIT.
- Latency: calc_done at cycle N gives tx_valid=1 with the first byte at cycle N+1 (no zero skipping).
- SIGN: tx_data=0x2D ('-'). On transfer, go to DIGIT.
- DIGIT:
  - nibble = mag[4*idx+3 -: 4].
  - ASCII mapping: 0–9 → 0x30+n; 10–15 → 0x37+n (uppercase 'A'–'F').
  - Skip rule: if SUPPRESS_ZEROS, no digit emitted yet, nibble==0 and idx!=0, skip the digit. A skipped digit takes one cycle with tx_valid=0, then idx decrements.
  - On transfer with idx==0, go to CR if APPEND_CRLF, else DONE. Otherwise idx decrements.
- CR: tx_data=0x0D; on transfer go to LF.
- LF: tx_data=0x0A; on transfer go to DONE.
- DONE: fmt_done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE. A calc_done in the DONE cycle is treated as overrun.
- Overrun: calc_done in any state other than IDLE:
  - pulses overrun in the next cycle;
  - is otherwise ignored;
  - the latched result is unchanged.
- calc_done and rst together: reset wins; no capture.
- Byte count without suppression: 8 digits + 1 if negative + 2 if APPEND_CRLF.

Decomposition:
- Package calc_fmt_pkg holds:
  - the FSM state encoding (3-bit localparams for IDLE..DONE);
  - ASCII constants: ASCII_MINUS=0x2D, ASCII_CR=0x0D, ASCII_LF=0x0A, ASCII_ZERO=0x30, ASCII_HEX_OFS=0x37.
- One combinational sub-module, nibble_to_ascii (4-bit in, 8-bit out). It is instantiated once in the DIGIT datapath.
- Magnitude negation, digit counter, FSM and output registers live in result_formatter.

Test Plan:
1. Defaults, calc_res=0x0000000A pulse, tx_ready=1 → bytes "0000000A" 0x0D 0x0A (10 transfers); first tx_valid one cycle after calc_done; fmt_done one cycle after LF transfer.
2. SIGNED=1, SUPPRESS_ZEROS=1, calc_res=0xFFFFFFFE → "-2\r\n" (0x2D,0x32,0x0D,0x0A); busy high throughout, 7 skip cycles with tx_valid low.
3. SUPPRESS_ZEROS=1, calc_res=0x00000000 → "0\r\n"; SIGNED=1 with 0x80000000 → "-80000000\r\n".
4. Backpressure: tx_ready low 5 cycles on the 3rd byte → tx_valid stays 1, tx_data stable; stream resumes with no loss or duplication.
5. Second calc_done (0x1234) during stream of 0xABCD → one-cycle overrun pulse; output continues "0000ABCD\r\n" unaltered.
6. rst asserted after 4 transfers → next cycle tx_valid=0, busy=0; fresh calc_done 0x1 yields a complete "00000001\r\n".
